// File: rtl/wb_arbiter2.sv
// Two-master, one-slave arbiter for the pipelined byte bus.
// Whole-cycle grants, round-robin ties, watchdog abort to DRAIN.
module wb_arbiter2 #(
   parameter int AW      = 7,
   parameter int DW      = 8,
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [1:0]      m_cyc_i,
   input  logic [1:0]      m_stb_i,
   input  logic [1:0]      m_we_i,
   input  logic [2*AW-1:0] m_adr_i,
   input  logic [2*DW-1:0] m_dat_i,
   output logic [1:0]      m_ack_o,
   output logic [1:0]      m_wat_o,
   output logic [1:0]      m_err_o,
   output logic [DW-1:0]   m_dat_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   input  logic            s_ack_i,
   input  logic            s_wat_i,
   input  logic            s_err_i,
   input  logic [DW-1:0]   s_dat_i,
   output logic [1:0]      gnt_o,
   output logic            timeout_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam bit WD_EN = (TIMEOUT > 0);
   localparam logic [TW-1:0] CMAX =
      TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic          drn_q, drn_d;
   logic [TW-1:0] cnt_q, cnt_d;

   logic own;
   logic n;
   logic g;
   logic abort;

   // Decode current owner and the watchdog abort condition
   always_comb begin
      own   = (state_q == OWN0) || (state_q == OWN1);
      n     = (state_q == OWN1);
      g     = (m_cyc_i == 2'b11) ? ~last_q : m_cyc_i[1];
      abort = WD_EN && own && m_cyc_i[n] && !s_ack_i
              && (cnt_q == CMAX);
   end

   // Next state, round-robin memory and watchdog count
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      drn_d   = drn_q;
      cnt_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (m_cyc_i != 2'b00) begin
               state_d = g ? OWN1 : OWN0;
               last_d  = g;
            end
         end
         OWN0, OWN1: begin
            if (!m_cyc_i[n]) begin
               if (m_cyc_i[~n]) begin
                  state_d = n ? OWN0 : OWN1;
                  last_d  = ~n;
               end else begin
                  state_d = IDLE;
               end
            end else if (abort) begin
               state_d = DRAIN;
               drn_d   = n;
            end else if (WD_EN && !s_ack_i) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (!m_cyc_i[drn_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers, async active-low reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         drn_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         drn_q   <= drn_d;
         cnt_q   <= cnt_d;
      end
   end

   // Bus muxing and response routing from the current state
   always_comb begin
      gnt_o     = {own & n, own & ~n};
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_adr_o   = '0;
      s_dat_o   = '0;
      m_ack_o   = 2'b00;
      m_err_o   = 2'b00;
      m_wat_o   = m_cyc_i;
      m_dat_o   = s_dat_i;
      timeout_o = abort;
      if (own) begin
         s_cyc_o    = m_cyc_i[n];
         s_stb_o    = m_stb_i[n];
         s_we_o     = m_we_i[n];
         s_adr_o    = m_adr_i[n*AW +: AW];
         s_dat_o    = m_dat_i[n*DW +: DW];
         m_ack_o[n] = s_ack_i;
         m_err_o[n] = s_err_i | abort;
         m_wat_o[n] = s_wat_i;
      end
      if (state_q == DRAIN) m_wat_o[drn_q] = 1'b0;
   end

endmodule
